// File: rtl/alpha_mean_pkg.sv
// Shared definitions for the Modified Alpha Mean Filter: state encoding and
// parameter derivations used by the sorter and the trimmed-mean stage.
package alpha_mean_pkg;

  // One-hot state codes for the trimmed-mean controller
  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_ACCUM  = 4'b0010;
  localparam logic [3:0] ST_DIVIDE = 4'b0100;
  localparam logic [3:0] ST_DONE   = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE   = ST_IDLE,
    S_ACCUM  = ST_ACCUM,
    S_DIVIDE = ST_DIVIDE,
    S_DONE   = ST_DONE
  } state_e;

  // Width of one sorted index (shared with the sorter)
  function automatic int seq_w(input int dn);
    return (dn > 1) ? $clog2(dn) : 1;
  endfunction

  // Number of samples surviving the trim at both ends
  function automatic int n_keep(input int dn, input int trim);
    return dn - 2 * trim;
  endfunction

  // Accumulator width: covers DN full-scale samples plus the rounding bias
  function automatic int sum_w(input int dn, input int dw);
    return dw + $clog2(dn) + 1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// A start pulse loads the dividend; W cycles later done pulses for one cycle
// with the final quotient presented combinationally in that same cycle.
module seq_divider #(
  parameter int W  = 14,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [W:0]    trial;
  logic [W:0]    diff;

  // One restoring step per cycle; diff[W] is the borrow that says trial < divisor
  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done     = 1'b0;
    trial    = {rem_q, quo_q[W-1]};
    diff     = trial - {1'b0, divisor};
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      cnt_d = CW'(W);
      run_d = 1'b1;
    end else if (run_q) begin
      if (!diff[W]) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = trial[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        done  = 1'b1;
        run_d = 1'b0;
      end
    end
    quotient = quo_d[QW-1:0];
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/alpha_trim_mean.sv
// Trimmed-mean stage of the Modified Alpha Mean Filter. Captures a window and
// its sorted index list, sums the middle N_KEEP samples one per cycle starting
// from a round-to-nearest bias, then divides sequentially by N_KEEP.
module alpha_trim_mean
  import alpha_mean_pkg::*;
#(
  parameter int DN          = 25,
  parameter int DW          = 8,
  parameter int DW_sequence = seq_w(DN),
  parameter int TRIM        = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sort_finish,
  input  logic [DW*DN-1:0]          data_unsort,
  input  logic [DW_sequence*DN-1:0] sequence_sorted,
  output logic [DW-1:0]             mean_out,
  output logic                      mean_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int N_KEEP = n_keep(DN, TRIM);
  localparam int SUM_W  = sum_w(DN, DW);
  localparam logic [DW_sequence-1:0] K_FIRST = DW_sequence'(TRIM);
  localparam logic [DW_sequence-1:0] K_LAST  = DW_sequence'(DN - TRIM - 1);
  localparam logic [SUM_W-1:0]       BIAS    = SUM_W'(N_KEEP / 2);
  localparam logic [SUM_W-1:0]       DIVISOR = SUM_W'(N_KEEP);

  if (2 * TRIM >= DN) begin : g_trim_check
    $error("alpha_trim_mean: 2*TRIM must be less than DN");
  end

  state_e                    state_q, state_d;
  logic [DW*DN-1:0]          data_q, data_d;
  logic [DW_sequence*DN-1:0] seq_q, seq_d;
  logic [SUM_W-1:0]          sum_q, sum_d;
  logic [DW_sequence-1:0]    k_q, k_d;
  logic [DW-1:0]             mean_out_q, mean_out_d;
  logic                      mean_valid_q, mean_valid_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;

  logic [DW_sequence-1:0]    cur_idx;
  logic [DW-1:0]             cur_sample;
  logic                      div_start;
  logic                      div_done;
  logic [DW-1:0]             div_quo;

  seq_divider #(
    .W  (SUM_W),
    .QW (DW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_d),
    .divisor  (DIVISOR),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Controller: capture, accumulate slot k, hand the sum to the divider, publish
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    seq_d        = seq_q;
    sum_d        = sum_q;
    k_d          = k_q;
    mean_out_d   = mean_out_q;
    mean_valid_d = 1'b0;
    div_start    = 1'b0;
    overrun_d    = sort_finish && (state_q != S_IDLE);
    cur_idx      = seq_q[k_q*DW_sequence +: DW_sequence];
    cur_sample   = data_q[cur_idx*DW +: DW];
    case (state_q)
      S_IDLE: begin
        if (sort_finish) begin
          data_d  = data_unsort;
          seq_d   = sequence_sorted;
          sum_d   = BIAS;
          k_d     = K_FIRST;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        sum_d = sum_q + SUM_W'(cur_sample);
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          // Divider loads the final sum on the same edge we enter DIVIDE
          div_start = 1'b1;
          state_d   = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (div_done) begin
          mean_out_d   = div_quo;
          mean_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, capture, accumulator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      seq_q        <= '0;
      sum_q        <= '0;
      k_q          <= '0;
      mean_out_q   <= '0;
      mean_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      seq_q        <= seq_d;
      sum_q        <= sum_d;
      k_q          <= k_d;
      mean_out_q   <= mean_out_d;
      mean_valid_q <= mean_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mean_out   = mean_out_q;
  assign mean_valid = mean_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_alpha_trim_mean.sv
// Scoreboard bench for alpha_trim_mean: stimulus pushes the expected mean and
// the cycle it must appear in; a monitor pops and compares on mean_valid.
module tb_alpha_trim_mean;

  localparam int DN  = 25;
  localparam int DW  = 8;
  localparam int SW  = 5;
  localparam int LAT = 28;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sort_finish = 1'b0;
  logic [DW*DN-1:0]  data_unsort = '0;
  logic [SW*DN-1:0]  sequence_sorted = '0;
  logic [DW-1:0]     mean_out;
  logic              mean_valid;
  logic              busy;
  logic              overrun;

  alpha_trim_mean dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sort_finish     (sort_finish),
    .data_unsort     (data_unsort),
    .sequence_sorted (sequence_sorted),
    .mean_out        (mean_out),
    .mean_valid      (mean_valid),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   rv[DN];
  int   t;
  int   t2;

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Place rank r's value at a position; seq slot r points at it
  task automatic build(input bit scramble);
    for (int r = 0; r < DN; r++) begin
      int pos;
      pos = scramble ? (r * 7) % DN : r;
      data_unsort[pos*DW +: DW]   = DW'(rv[r]);
      sequence_sorted[r*SW +: SW] = SW'(pos);
    end
  endtask

  task automatic pulse(input bit expect_res, input int exp_val, output int tt);
    exp_t e;
    @(posedge clk); #1;
    sort_finish = 1'b1;
    tt = cyc;
    if (expect_res) begin
      e.val = exp_val;
      e.cyc = tt + LAT;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    sort_finish = 1'b0;
  endtask

  task automatic go_neg(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every mean_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && mean_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: mean_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("mean_out", int'(mean_out), mon_e.val);
        check("valid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mean_out", int'(mean_out), 0);
    check("rst_mean_valid", int'(mean_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All samples 100, scrambled order
    for (int r = 0; r < DN; r++) rv[r] = 100;
    build(1'b1);
    pulse(1'b1, 100, t);
    go_neg(t + 1);
    check("busy_first", int'(busy), 1);
    go_neg(t + 28);
    check("busy_done", int'(busy), 1);
    go_neg(t + 29);
    check("busy_after", int'(busy), 0);
    check("mean_held", int'(mean_out), 100);
    drain();

    // Ramp with identity ordering: (156 + 6) / 13 -> 12
    for (int r = 0; r < DN; r++) rv[r] = r;
    build(1'b0);
    pulse(1'b1, 12, t);
    drain();

    // Outliers 0 and 255 trimmed away
    for (int r = 0; r < DN; r++) rv[r] = (r < 6) ? 0 : (r > 18) ? 255 : 40;
    build(1'b1);
    pulse(1'b1, 40, t);
    drain();

    // Different trimmed values, same kept set
    for (int r = 0; r < DN; r++) rv[r] = (r < 6) ? r * 5 : (r > 18) ? 200 + r : 40;
    build(1'b1);
    pulse(1'b1, 40, t);
    drain();

    // Rounding up: kept sum 137 -> (137 + 6) / 13 = 11
    for (int r = 0; r < DN; r++) rv[r] = (r < 6) ? 0 : (r > 18) ? 200 : (r == 18) ? 17 : 10;
    build(1'b1);
    pulse(1'b1, 11, t);
    drain();

    // Rounding down: kept sum 136 -> (136 + 6) / 13 = 10
    for (int r = 0; r < DN; r++) rv[r] = (r < 6) ? 0 : (r > 18) ? 200 : (r == 18) ? 16 : 10;
    build(1'b1);
    pulse(1'b1, 10, t);
    drain();

    // Overrun: second sort_finish at T+5 is ignored
    for (int r = 0; r < DN; r++) rv[r] = r;
    build(1'b0);
    pulse(1'b1, 12, t);
    repeat (3) @(posedge clk);
    for (int r = 0; r < DN; r++) rv[r] = 100;
    build(1'b1);
    pulse(1'b0, 0, t2);
    go_neg(t + 6);
    check("overrun_pulse", int'(overrun), 1);
    check("overrun_busy", int'(busy), 1);
    go_neg(t + 7);
    check("overrun_clear", int'(overrun), 0);
    drain();
    repeat (10) @(negedge clk);

    // Reset asserted during DIVIDE aborts the window
    for (int r = 0; r < DN; r++) rv[r] = (r < 6) ? 0 : (r > 18) ? 255 : 40;
    build(1'b1);
    pulse(1'b0, 0, t);
    go_neg(t + 20);
    rst_n = 1'b0;
    #1;
    check("abort_mean_out", int'(mean_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(mean_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go_neg(t + 40);

    // Fresh window after reset release
    for (int r = 0; r < DN; r++) rv[r] = (r < 6) ? r * 5 : (r > 18) ? 200 + r : 40;
    build(1'b1);
    pulse(1'b1, 40, t);
    drain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
